// File: rtl/uart_tx_sched_pkg.sv
// Shared types and constants for the UART transmit scheduler.
package uart_tx_sched_pkg;

  // Frame sequencer states
  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    LOAD      = 3'd1,
    START     = 3'd2,
    WAIT_ACK  = 3'd3,
    WAIT_DONE = 3'd4
  } state_e;

  // Default first byte of every frame; receivers resynchronise on it
  localparam logic [7:0] SYNC_BYTE_DEF = 8'hA5;

  // Frame = sync + index + payload + checksum
  function automatic int frame_len(input int pb);
    return pb + 3;
  endfunction

endpackage

// File: rtl/uart_tx_sched_rr_arbiter.sv
// Combinational round-robin pick: first set request at or above ptr_i, wrapping.
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int PW      = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [PW-1:0]      ptr_i,
  output logic [PW-1:0]      winner_o,
  output logic               valid_o
);

  // Scan from farthest to nearest so the nearest set bit wins the last write
  always_comb begin
    int j;
    logic [PW-1:0] jj;
    winner_o = '0;
    valid_o  = 1'b0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      j = int'(ptr_i) + i;
      if (j >= NUM_REQ) j = j - NUM_REQ;
      jj = PW'(j);
      if (req_i[jj]) begin
        winner_o = jj;
        valid_o  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_tx_sched.sv
// Round-robin frame scheduler feeding a single uart_tx byte transmitter.
module uart_tx_sched
  import uart_tx_sched_pkg::*;
#(
  parameter int         NUM_REQ       = 4,
  parameter int         PAYLOAD_BYTES = 2,
  parameter logic [7:0] SYNC_BYTE     = SYNC_BYTE_DEF
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [NUM_REQ-1:0]               req_i,
  input  logic [NUM_REQ*PAYLOAD_BYTES*8-1:0] payload_i,
  output logic [NUM_REQ-1:0]               grant_o,
  output logic                             sched_busy_o,
  output logic                             uart_start_o,
  output logic [7:0]                       uart_data_o,
  input  logic                             uart_busy_i
);

  localparam int            PW      = $clog2(NUM_REQ);
  localparam int            PLW     = PAYLOAD_BYTES * 8;
  localparam int            FLEN    = frame_len(PAYLOAD_BYTES);
  localparam int            BW      = $clog2(FLEN);
  localparam logic [BW-1:0] LAST    = BW'(FLEN - 1);
  localparam logic [PW-1:0] PTR_MAX = PW'(NUM_REQ - 1);

  state_e             state_q;
  logic [PW-1:0]      rr_ptr_q, rr_ptr_d;
  logic [PW-1:0]      win_q;
  logic [BW-1:0]      byte_idx_q;
  logic [PLW-1:0]     payload_q;
  logic [7:0]         csum_q, csum_d;
  logic [NUM_REQ-1:0] grant_q;
  logic               sched_busy_q;
  logic               uart_start_q;
  logic [7:0]         uart_data_q;

  logic [PW-1:0]      arb_win;
  logic               arb_vld;
  logic [PLW-1:0]     pl_sel;
  logic [BW-1:0]      sel_idx;
  logic [7:0]         fbyte;

  rr_arbiter #(.NUM_REQ(NUM_REQ), .PW(PW)) u_arb (
    .req_i    (req_i),
    .ptr_i    (rr_ptr_q),
    .winner_o (arb_win),
    .valid_o  (arb_vld)
  );

  // Winner's payload, its checksum, and the pointer just past the winner
  always_comb begin
    pl_sel = '0;
    for (int i = 0; i < NUM_REQ; i++)
      if (arb_win == PW'(i)) pl_sel = payload_i[i*PLW +: PLW];
    csum_d = {{(8-PW){1'b0}}, arb_win};
    for (int b = 0; b < PAYLOAD_BYTES; b++)
      csum_d = csum_d ^ pl_sel[b*8 +: 8];
    rr_ptr_d = (arb_win == PTR_MAX) ? '0 : arb_win + PW'(1);
  end

  // Frame byte to issue next; in WAIT_DONE we look one byte ahead
  always_comb begin
    sel_idx = (state_q == WAIT_DONE) ? byte_idx_q + BW'(1) : byte_idx_q;
    fbyte   = SYNC_BYTE;
    if (sel_idx == BW'(1)) fbyte = {{(8-PW){1'b0}}, win_q};
    for (int b = 0; b < PAYLOAD_BYTES; b++)
      if (sel_idx == BW'(b + 2)) fbyte = payload_q[(PAYLOAD_BYTES-1-b)*8 +: 8];
    if (sel_idx == LAST) fbyte = csum_q;
  end

  // Sequencer: arbitrate, latch, then hand bytes to uart_tx one handshake at a time
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      rr_ptr_q     <= '0;
      win_q        <= '0;
      byte_idx_q   <= '0;
      payload_q    <= '0;
      csum_q       <= '0;
      grant_q      <= '0;
      sched_busy_q <= 1'b0;
      uart_start_q <= 1'b0;
      uart_data_q  <= '0;
    end else begin
      grant_q      <= '0;
      uart_start_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (arb_vld) begin
            state_q      <= LOAD;
            grant_q      <= NUM_REQ'(1) << arb_win;
            win_q        <= arb_win;
            rr_ptr_q     <= rr_ptr_d;
            payload_q    <= pl_sel;
            csum_q       <= csum_d;
            byte_idx_q   <= '0;
            sched_busy_q <= 1'b1;
          end
        end
        LOAD: begin
          // uart_tx may still be busy with someone else; START then holds
          state_q <= START;
          if (!uart_busy_i) begin
            uart_start_q <= 1'b1;
            uart_data_q  <= fbyte;
          end
        end
        START: begin
          if (uart_start_q) begin
            state_q <= WAIT_ACK;
          end else if (!uart_busy_i) begin
            uart_start_q <= 1'b1;
            uart_data_q  <= fbyte;
          end
        end
        WAIT_ACK: begin
          if (uart_busy_i) state_q <= WAIT_DONE;
        end
        WAIT_DONE: begin
          if (!uart_busy_i) begin
            if (byte_idx_q == LAST) begin
              state_q      <= IDLE;
              sched_busy_q <= 1'b0;
            end else begin
              byte_idx_q   <= byte_idx_q + BW'(1);
              state_q      <= START;
              uart_start_q <= 1'b1;
              uart_data_q  <= fbyte;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign grant_o      = grant_q;
  assign sched_busy_o = sched_busy_q;
  assign uart_start_o = uart_start_q;
  assign uart_data_o  = uart_data_q;

endmodule

// File: tb/tb_uart_tx_sched.sv
// Directed bench for uart_tx_sched with a simple uart_tx busy model.
module tb_uart_tx_sched;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [3:0]  req = '0;
  logic [63:0] payload = 64'hC3C3_1234_5A3C_BEEF;
  logic [3:0]  grant;
  logic        sched_busy, uart_start, uart_busy;
  logic [7:0]  uart_data;
  logic        force_busy = 1'b0;
  int          cnt = 0;
  int          checks = 0;
  int          failures = 0;
  logic [7:0]  bytes[$];

  uart_tx_sched #(.NUM_REQ(4), .PAYLOAD_BYTES(2), .SYNC_BYTE(8'hA5)) dut (
    .clk          (clk),
    .reset        (reset),
    .req_i        (req),
    .payload_i    (payload),
    .grant_o      (grant),
    .sched_busy_o (sched_busy),
    .uart_start_o (uart_start),
    .uart_data_o  (uart_data),
    .uart_busy_i  (uart_busy)
  );

  always #5 clk = ~clk;

  // uart_tx stand-in: busy for 10 cycles after each start pulse
  always @(posedge clk or posedge reset)
    if (reset) cnt <= 0;
    else if (uart_start) cnt <= 10;
    else if (cnt > 0) cnt <= cnt - 1;

  assign uart_busy = (cnt != 0) || force_busy;

  always @(negedge clk) if (uart_start) bytes.push_back(uart_data);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic wait_grant(input string tag, output logic [3:0] g);
    g = '0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (|grant) begin
        g = grant;
        return;
      end
    end
    checks++;
    failures++;
    $error("FAIL %s grant timeout observed=none expected=grant", tag);
  endtask

  task automatic wait_idle(input string tag);
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (!sched_busy) return;
    end
    checks++;
    failures++;
    $error("FAIL %s idle timeout observed=busy expected=idle", tag);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  initial begin
    logic [3:0] g;
    logic [3:0] gl[5];
    logic [3:0] exp_g[5];
    logic [7:0] exp1[5];
    logic [7:0] exp_idx[5];
    int n, gcount;
    logic was_idle;
    exp_g   = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    exp1    = '{8'hA5, 8'h02, 8'h12, 8'h34, 8'h24};
    exp_idx = '{8'h00, 8'h01, 8'h02, 8'h03, 8'h00};
    gl      = '{default: 4'b0};

    // reset values
    repeat (2) tick();
    chk("rst_grant", grant, 4'b0);
    chk("rst_busy", sched_busy, 1'b0);
    chk("rst_start", uart_start, 1'b0);
    chk("rst_data", uart_data, 8'h00);
    reset = 1'b0;
    tick();

    // single requester 2, latency and frame contents
    bytes.delete();
    req = 4'b0100;
    tick();
    chk("t1_grant", grant, 4'b0100);
    chk("t1_busy", sched_busy, 1'b1);
    req = 4'b0000;
    tick();
    chk("t1_grant_pulse", grant, 4'b0000);
    chk("t1_start", uart_start, 1'b1);
    chk("t1_sync", uart_data, 8'hA5);
    wait_idle("t1");
    chk("t1_nbytes", bytes.size(), 5);
    for (int k = 0; k < 5; k++) chk($sformatf("t1_b%0d", k), bytes[k], exp1[k]);

    // all requesting from a fresh pointer: strict rotation
    do_reset();
    bytes.delete();
    req = 4'b1111;
    n = 0;
    for (int i = 0; i < 3000 && n < 5; i++) begin
      tick();
      if (|grant) begin
        gl[n] = grant;
        n++;
        if (n == 5) req = 4'b0000;
      end
    end
    chk("t3_ngrants", n, 5);
    wait_idle("t3");
    for (int k = 0; k < 5; k++) chk($sformatf("t3_grant%0d", k), gl[k], exp_g[k]);
    chk("t3_nbytes", bytes.size(), 25);
    for (int k = 0; k < 5; k++) chk($sformatf("t3_idx%0d", k), bytes[5*k+1], exp_idx[k]);
    chk("t3_csum0", bytes[4], 8'h51);
    chk("t3_csum1", bytes[9], 8'h67);

    // requester 3 wraps the pointer to 0, then 0 wins over 3
    req = 4'b1000;
    wait_grant("t4a", g);
    chk("t4_grant3", g, 4'b1000);
    req = 4'b1001;
    wait_grant("t4b", g);
    chk("t4_grant0", g, 4'b0001);
    req = 4'b1000;
    wait_grant("t4c", g);
    chk("t4_grant3b", g, 4'b1000);
    req = 4'b0000;
    wait_idle("t4");

    // uart_tx busy from elsewhere: START holds off
    bytes.delete();
    force_busy = 1'b1;
    req = 4'b0010;
    tick();
    chk("t5_grant", grant, 4'b0010);
    req = 4'b0000;
    for (int k = 0; k < 7; k++) begin
      tick();
      chk($sformatf("t5_hold%0d", k), uart_start, 1'b0);
    end
    force_busy = 1'b0;
    tick();
    chk("t5_start", uart_start, 1'b1);
    chk("t5_sync", uart_data, 8'hA5);
    wait_idle("t5");

    // asynchronous reset in the middle of the payload
    bytes.delete();
    req = 4'b0110;
    for (int i = 0; i < 500 && bytes.size() < 3; i++) tick();
    chk("t6_midbusy", sched_busy, 1'b1);
    #2 reset = 1'b1;
    #1;
    chk("t6_grant", grant, 4'b0);
    chk("t6_start", uart_start, 1'b0);
    chk("t6_busy", sched_busy, 1'b0);
    chk("t6_data", uart_data, 8'h00);
    tick();
    reset = 1'b0;
    bytes.delete();
    wait_grant("t6", g);
    chk("t6_regrant", g, 4'b0010);
    req = 4'b0000;
    wait_idle("t6");
    chk("t6_sync", bytes[0], 8'hA5);
    chk("t6_idx", bytes[1], 8'h01);
    chk("t6_csum", bytes[4], 8'h67);

    // request pulsed and dropped mid-frame is never granted
    req = 4'b0001;
    wait_grant("t7a", g);
    chk("t7_grant0", g, 4'b0001);
    req = 4'b0000;
    repeat (3) tick();
    req = 4'b0100;
    repeat (5) tick();
    req = 4'b0000;
    gcount = 0;
    for (int i = 0; i < 2000 && sched_busy; i++) begin
      tick();
      if (|grant) gcount++;
    end
    for (int i = 0; i < 5; i++) begin
      tick();
      if (|grant) gcount++;
    end
    chk("t7_nogrant", gcount, 0);

    // request raised mid-frame is granted only after the frame ends
    req = 4'b0001;
    wait_grant("t7b", g);
    req = 4'b0000;
    repeat (3) tick();
    req = 4'b0010;
    was_idle = 1'b0;
    g = '0;
    for (int i = 0; i < 1000; i++) begin
      tick();
      if (!sched_busy) was_idle = 1'b1;
      if (|grant) begin
        g = grant;
        break;
      end
    end
    chk("t7_late_grant", g, 4'b0010);
    chk("t7_after_idle", was_idle, 1'b1);
    req = 4'b0000;
    wait_idle("t7");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
